demux_1x4_stream: RTL and testbench
===================================

# demux_1x4_stream

Stream demultiplexer, the inverse of our 4:1 n-bit mux. It accepts one n-bit word per handshake on a single input channel and routes it, by a 2-bit destination select, into one of four registered output channels. Each output channel has its own one-entry buffer and valid/ready handshake, so a stalled consumer blocks only traffic addressed to it. It sits between a shared producer, such as a bus or decoder front end, and four independent consumers.

## Interface
Parameters:
- n, 4, payload width in bits
- CNT_W, 8, width of per-channel transfer counters

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- w  input  n  input payload
- s  input  2  destination channel for w (00→f0, 01→f1, 10→f2, 11→f3)
- in_valid  input  1  w/s valid this cycle
- in_ready  output  1  demux can accept the word addressed by s this cycle
- f0, f1, f2, f3  output  n each  registered channel payloads
- out_valid  output  4  bit k: fk holds an undelivered word
- out_ready  input  4  bit k: consumer k accepts fk this cycle
- cnt0..cnt3  output  CNT_W each  words delivered out of channel k (out_valid[k] & out_ready[k]), wrapping

## Operation
- Slot k state: full flag (drives out_valid[k]) and data register (drives fk).
- in_ready = ~reset & (~out_valid[s] | out_ready[s]); combinational from s, out_valid, out_ready. Only the addressed slot matters.
- Accept = in_valid & in_ready. On accept, slot s loads w and sets full.
- Slot k drains when out_valid[k] & out_ready[k]. It clears full unless the same edge also loads k from an accept.
- Simultaneous drain and load on the same slot: the new word replaces the old one, full stays 1, and throughput is one word per cycle per channel.
- Simultaneous drain on slot j and load on slot k (j≠k): both happen independently.
- in_valid=0: s is don't-care and no slot changes. in_ready still reflects s.
- s may change while in_valid=1 and stalled. Routing follows the current s, with no latching; the producer is responsible for holding s stable if it needs ordering.
- Data registers keep their last value after drain. fk is meaningful only when out_valid[k]=1.
- cntk increments by 1 on each drain of slot k and wraps from 2^CNT_W−1 to 0.
- Words routed to different channels never reorder within a channel. There is no ordering guarantee across channels.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert release): out_valid=4'b0000, f0..f3=0, cnt0..cnt3=0, in_ready=0 while reset=1.
- Latency: a word accepted at edge t is visible on fk with out_valid[k]=1 immediately after edge t. That is one cycle from in_valid to out_valid.
- Throughput: 1 word/cycle total, limited by the single input.
- Reset asserted mid-operation: all buffered words are discarded, counters clear, and no handshake completes on that edge.
- First cycle after reset release: in_ready=1 for any s.
- No combinational path from w to any output. There are combinational paths s/out_ready/out_valid → in_ready.

## Structure
- Shared package demux_pkg holds: default N=4, SEL_W=2, NUM_CH=4, CNT_W=8, and channel index constants CH0..CH3 = 2'd0..2'd3.
- Sub-module demux_slot is a one-entry valid/ready register with parameter n. Its ports are clk, reset, load, d, out_ready, out_valid, q, drain, and cnt[CNT_W-1:0]. It is instantiated 4×.
- The top contains only address decode (load[k] = accept & (s==k)), the in_ready mux, and instances.

## Test plan
- Reset check: assert reset mid-stream with slots 0 and 2 full. Required: out_valid=0000, all f=0, all cnt=0 and in_ready=0 immediately (asynchronous). After release, in_ready=1.
- Basic routing: send w=4'hA to s=00, 4'h5 to s=01, 4'hC to s=10, 4'h3 to s=11, with all out_ready=0. Required: out_valid=1111, f0..f3=A,5,C,3. A fifth word to s=01 sees in_ready=0.
- Back-pressure isolation: slot 1 full with out_ready[1]=0. in_valid with s=01 gets in_ready=0. Switching s to 10 gives in_ready=1, and 4'h7 lands in f2 while f1 stays 5.
- Full-rate pass-through: out_ready[3]=1 held high, 6 consecutive words 1..6 to s=11. Required: in_ready=1 every cycle, f3 shows 1..6 on consecutive cycles, cnt3=6.
- Simultaneous drain/load: slot 0 holds 4'h9 and out_ready[0]=1 while accepting 4'hE to s=00. Required: next cycle f0=E, out_valid[0]=1, cnt0 incremented by 1.
- Counter wrap: with CNT_W=8, deliver 257 words on channel 2. Required: cnt2=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer slice.
package demux_pkg;

    localparam int unsigned N      = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output buffer with a wrapping delivered-word counter.
module demux_slot #(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [n-1:0]     d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [n-1:0]     q,
    output logic             drain,
    output logic [CNT_W-1:0] cnt
);

    assign drain = out_valid & out_ready;

    // A load on the same edge as a drain wins, so the slot stays full at full rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            q         <= '0;
            cnt       <= '0;
        end else begin
            if (load) begin
                q         <= d;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// Routes one input stream word per handshake into one of four buffered output channels.
module demux_1x4_stream #(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [n-1:0]     w,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [n-1:0]     f0,
    output logic [n-1:0]     f1,
    output logic [n-1:0]     f2,
    output logic [n-1:0]     f3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    import demux_pkg::*;

    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic [n-1:0]      q   [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    // ~valid | ready == ~valid | drain; only the addressed slot gates acceptance.
    assign in_ready = ~reset & (~out_valid[s] | drain[s]);
    assign accept   = in_valid & in_ready;

    assign load = {accept & (s == CH3),
                   accept & (s == CH2),
                   accept & (s == CH1),
                   accept & (s == CH0)};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .n     (n),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .d         (w),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .q         (q[k]),
            .drain     (drain[k]),
            .cnt       (cnt[k])
        );
    end

    assign f0   = q[0];
    assign f1   = q[1];
    assign f2   = q[2];
    assign f3   = q[3];
    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed self-checking bench for demux_1x4_stream.
module tb_demux_1x4_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] w;
    logic [1:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] f0, f1, f2, f3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1x4_stream #(
        .n     (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .w         (w),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f0        (f0),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ss, input logic [3:0] ww,
                         input logic [3:0] rdy);
        in_valid  = v;
        s         = ss;
        w         = ww;
        out_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; s = 2'd0; w = 4'h0; out_ready = 4'h0;
        tick();
        tick();
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_ir", 32'(in_ready), 32'h0);
        reset = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b0, 2'(i), 4'h0, 4'h0);
            chk("post_rst_ir", 32'(in_ready), 32'h1);
        end

        // basic routing with all consumers stalled
        drive(1'b1, 2'd0, 4'hA, 4'h0); chk("rt_ir0", 32'(in_ready), 32'h1); tick();
        drive(1'b1, 2'd1, 4'h5, 4'h0); chk("rt_ir1", 32'(in_ready), 32'h1); tick();
        drive(1'b1, 2'd2, 4'hC, 4'h0); chk("rt_ir2", 32'(in_ready), 32'h1); tick();
        drive(1'b1, 2'd3, 4'h3, 4'h0); chk("rt_ir3", 32'(in_ready), 32'h1); tick();
        chk("rt_ov", 32'(out_valid), 32'hF);
        chk("rt_f0", 32'(f0), 32'hA);
        chk("rt_f1", 32'(f1), 32'h5);
        chk("rt_f2", 32'(f2), 32'hC);
        chk("rt_f3", 32'(f3), 32'h3);
        drive(1'b1, 2'd1, 4'h9, 4'h0);
        chk("fifth_ir", 32'(in_ready), 32'h0);
        tick();
        chk("fifth_f1", 32'(f1), 32'h5);
        chk("fifth_ov", 32'(out_valid), 32'hF);

        // drain slot 2 only
        drive(1'b0, 2'd0, 4'h0, 4'b0100); tick();
        chk("drn2_ov", 32'(out_valid), 32'hB);
        chk("drn2_cnt", 32'(cnt2), 32'h1);
        chk("drn2_hold", 32'(f2), 32'hC);

        // back-pressure isolation
        drive(1'b1, 2'd1, 4'h7, 4'h0); chk("bp_ir1", 32'(in_ready), 32'h0);
        drive(1'b1, 2'd2, 4'h7, 4'h0); chk("bp_ir2", 32'(in_ready), 32'h1);
        tick();
        chk("bp_f2", 32'(f2), 32'h7);
        chk("bp_f1", 32'(f1), 32'h5);
        chk("bp_ov", 32'(out_valid), 32'hF);

        // full-rate pass-through on channel 3
        for (int unsigned i = 1; i <= 6; i++) begin
            drive(1'b1, 2'd3, 4'(i), 4'b1000);
            chk("fr_ir", 32'(in_ready), 32'h1);
            tick();
            chk("fr_f3", 32'(f3), i);
            chk("fr_ov3", 32'(out_valid[3]), 32'h1);
        end
        chk("fr_cnt3", 32'(cnt3), 32'h6);
        drive(1'b0, 2'd3, 4'h0, 4'b1000); tick();
        chk("fr_end_ov", 32'(out_valid), 32'h7);
        chk("fr_end_cnt3", 32'(cnt3), 32'h7);

        // idle input leaves slots untouched
        drive(1'b0, 2'd1, 4'hF, 4'h0); tick();
        chk("idle_ov", 32'(out_valid), 32'h7);
        chk("idle_f1", 32'(f1), 32'h5);

        // simultaneous drain and load on slot 0
        drive(1'b1, 2'd0, 4'h9, 4'b0001); chk("sim_ir_a", 32'(in_ready), 32'h1); tick();
        chk("sim_f0_a", 32'(f0), 32'h9);
        chk("sim_cnt0_a", 32'(cnt0), 32'h1);
        drive(1'b1, 2'd0, 4'hE, 4'b0001); chk("sim_ir_b", 32'(in_ready), 32'h1); tick();
        chk("sim_f0_b", 32'(f0), 32'hE);
        chk("sim_ov0", 32'(out_valid[0]), 32'h1);
        chk("sim_cnt0_b", 32'(cnt0), 32'h2);

        // asynchronous reset with slots 0 and 2 full
        drive(1'b1, 2'd2, 4'h4, 4'h0);
        reset = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'h0);
        chk("arst_f", 32'({f0, f1, f2, f3}), 32'h0);
        chk("arst_cnt", 32'({cnt0, cnt1, cnt2, cnt3}), 32'h0);
        chk("arst_ir", 32'(in_ready), 32'h0);
        tick();
        chk("arst_edge_ov", 32'(out_valid), 32'h0);
        reset = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b0, 2'(i), 4'h0, 4'h0);
            chk("arst_rel_ir", 32'(in_ready), 32'h1);
        end

        // 257 deliveries on channel 2 wrap the 8-bit counter to 1
        for (int unsigned i = 0; i < 257; i++) begin
            drive(1'b1, 2'd2, 4'(i), 4'b0100);
            chk("wrap_ir", 32'(in_ready), 32'h1);
            tick();
        end
        chk("wrap_cnt_zero", 32'(cnt2), 32'h0);
        chk("wrap_f2", 32'(f2), 32'h0);
        chk("wrap_ov2", 32'(out_valid[2]), 32'h1);
        drive(1'b0, 2'd0, 4'h0, 4'b0100); tick();
        chk("wrap_cnt2", 32'(cnt2), 32'h1);
        chk("wrap_end_ov", 32'(out_valid), 32'h0);
        chk("wrap_others", 32'({cnt0, cnt1, cnt3}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
